j1_stack_checked: RTL and testbench
===================================

Name: j1_stack_checked

Overview:
- Parametrised successor to the J1 core's data and return stack primitives.
- Circular register-file stack with configurable width, depth and number of read taps (1..3).
- Adds behaviour the current primitives lack: occupancy tracking, sticky overflow/underflow flags, a one-cycle fault pulse and a synchronous clear.
- Instantiated twice in the next core revision: return stack with RD_PORTS=1, data stack with RD_PORTS=3. The core's own TOS register stays outside the block.

Parameters:
- WIDTH, 16: data word width in bits.
- DEPTH, 32: number of entries. Must be a power of two and at least 4.
- RD_PORTS, 2: number of active read taps, 1..3. Inactive taps drive zero.

Ports:
- clk, input, 1: clock, rising edge.
- resetq, input, 1: asynchronous, active-low reset.
- we, input, 1: write wd into the slot addressed after the pointer move.
- wd, input, WIDTH: write data.
- delta, input, 2: pointer move. 00 = none, 01 = +1 (push), 11 = -1 (pop), 10 = -2 (pop two).
- clear, input, 1: synchronous empty (sp=0, level=0).
- clr_flags, input, 1: synchronously clear the sticky flags.
- rd1, output, WIDTH: entry at sp.
- rd2, output, WIDTH: entry at sp-1 (mod DEPTH). Zero if RD_PORTS<2.
- rd3, output, WIDTH: entry at sp-2 (mod DEPTH). Zero if RD_PORTS<3.
- level, output, $clog2(DEPTH+1): logical occupancy, 0..DEPTH.
- empty, output, 1: level==0.
- full, output, 1: level==DEPTH.
- overflow, output, 1: sticky; set by a push at full.
- underflow, output, 1: sticky; set by a pop past empty.
- fault, output, 1: one-cycle pulse in the cycle after any overflow or underflow event.

Behaviour:
- Reset (resetq low, asynchronous): sp=0, level=0, overflow=0, underflow=0, fault=0. Storage is not reset; reads of never-written slots are undefined and must not be checked.
- Reads are combinational from registered sp and storage. A write at edge N is visible on rd1 after edge N.
- Each rising edge, when clear=0:
  - sp <= sp + sign_extend(delta), modulo DEPTH. The pointer always moves, even on fault.
  - If we=1: mem[sp + sign_extend(delta)] <= wd.
    - we with delta=00 overwrites the current top.
    - we with delta=11 writes the new top (replace-under).
- Level update:
  - push: level+1; if level==DEPTH, level stays DEPTH, set overflow, pulse fault. The data is still written; the oldest entry is silently overwritten (wrap).
  - pop1: level-1; if level==0, level stays 0, set underflow, pulse fault.
  - pop2: level-2; if level<2, level becomes 0, set underflow, pulse fault.
  - none: level unchanged.
- clear=1: sp <= 0, level <= 0. delta is ignored, we is ignored, and no fault is raised. Flags are untouched unless clr_flags is also asserted.
- clr_flags=1 clears both sticky flags. If a new overflow/underflow event occurs in the same cycle, set wins.
- fault is registered: it is high for exactly the one cycle following the event edge and is never held.
- No internal state machine beyond sp/level/flags. All control is single-cycle with no handshake, so the block never stalls the core.

Decomposition:
- Package j1_stack_pkg:
  - Delta encodings DELTA_NONE=2'b00, DELTA_PUSH=2'b01, DELTA_POP1=2'b11, DELTA_POP2=2'b10.
  - Helper function for sign-extending delta to the pointer width.
- Sub-module j1_stack_occupancy: level counter, saturation, sticky flags and fault pulse. Inputs delta, clear, clr_flags. Storage and pointer logic stay in the top.

Test Plan:
- Reset, then push 0x0011, 0x0022, 0x0033 with we=1 -> rd1=0x0033, rd2=0x0022, rd3=0x0011, level=3, no flags.
- From level 3, pop2 -> rd1=0x0011, level=1. Then pop2 again -> level=0, underflow=1, fault high for exactly one cycle, sp moved by -2.
- DEPTH=32: push 33 words 0x0100..0x0120 -> after the 33rd push, overflow=1, full=1, level=32, rd1=0x0120, and slot 0x0100 is overwritten.
- we with delta=00 and wd=0xBEEF at level 2 -> rd1=0xBEEF, rd2 unchanged, level=2. we with delta=11 and wd=0x1234 -> rd1=0x1234, level=1.
- Same-cycle events:
  - clr_flags=1 with a pop at empty -> underflow remains 1.
  - clear=1 with push -> level=0, sp=0, no fault.
- Assert resetq low mid-sequence (level=5, overflow set) asynchronously between edges -> level, flags and fault drop to 0 immediately. After release, the first push gives level=1.

Source files
------------

// File: rtl/j1_stack_pkg.sv
// Shared types and helpers for the J1 circular stack.
// Delta encodings match the J1 instruction field directly.
package j1_stack_pkg;

  typedef enum logic [1:0] {
    DELTA_NONE = 2'b00,
    DELTA_PUSH = 2'b01,
    DELTA_POP2 = 2'b10,
    DELTA_POP1 = 2'b11
  } delta_e;

  // Callers truncate the result to their pointer width.
  function automatic logic [31:0] sext_delta(input logic [1:0] d);
    return {{30{d[1]}}, d};
  endfunction

endpackage

// File: rtl/j1_stack_occupancy.sv
// Occupancy tracking for the J1 stack: level, sticky flags,
// and a registered one-cycle fault pulse.
module j1_stack_occupancy
  import j1_stack_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic [1:0]    delta,
  input  logic          clear,
  input  logic          clr_flags,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic          underflow,
  output logic          fault
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_LVL  = LW'(1);
  localparam logic [LW-1:0] TWO_LVL  = LW'(2);

  delta_e dl;
  assign dl = delta_e'(delta);

  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          fault_q, fault_d;
  logic          ovf_ev, unf_ev;

  always_comb begin
    level_d = level_q;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    if (clear) begin
      level_d = '0;
    end else begin
      unique case (dl)
        DELTA_PUSH: begin
          if (level_q == FULL_LVL) ovf_ev = 1'b1;
          else level_d = level_q + ONE_LVL;
        end
        DELTA_POP1: begin
          if (level_q == '0) unf_ev = 1'b1;
          else level_d = level_q - ONE_LVL;
        end
        DELTA_POP2: begin
          if (level_q < TWO_LVL) begin
            unf_ev  = 1'b1;
            level_d = '0;
          end else begin
            level_d = level_q - TWO_LVL;
          end
        end
        DELTA_NONE: ;
        default: ;
      endcase
    end
  end

  // A fresh event wins over a same-cycle flag clear.
  always_comb begin
    overflow_d  = ovf_ev | (overflow_q & ~clr_flags);
    underflow_d = unf_ev | (underflow_q & ~clr_flags);
    fault_d     = ovf_ev | unf_ev;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      fault_q     <= fault_d;
    end
  end

  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign fault     = fault_q;

endmodule

// File: rtl/j1_stack_checked.sv
// Circular register-file stack with up to three read taps,
// occupancy tracking and sticky overflow/underflow flags.
module j1_stack_checked
  import j1_stack_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int RD_PORTS = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  input  logic [1:0]       delta,
  input  logic             clear,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             fault
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("j1_stack_checked: DEPTH must be a power of two >= 4");
  end
  if (RD_PORTS < 1 || RD_PORTS > 3) begin : g_bad_ports
    $error("j1_stack_checked: RD_PORTS must be 1..3");
  end

  localparam logic [PW-1:0] ONE_SP = PW'(1);
  localparam logic [PW-1:0] TWO_SP = PW'(2);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    sp_q, sp_d;
  logic             mem_we;

  // The write lands on the post-move slot, so push/replace work in one edge.
  always_comb begin
    if (clear) sp_d = '0;
    else       sp_d = sp_q + PW'(sext_delta(delta));
    mem_we = we & ~clear;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) sp_q <= '0;
    else         sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[sp_d] <= wd;
  end

  assign rd1 = mem_q[sp_q];

  if (RD_PORTS >= 2) begin : g_rd2
    assign rd2 = mem_q[sp_q - ONE_SP];
  end else begin : g_rd2_off
    assign rd2 = '0;
  end

  if (RD_PORTS >= 3) begin : g_rd3
    assign rd3 = mem_q[sp_q - TWO_SP];
  end else begin : g_rd3_off
    assign rd3 = '0;
  end

  j1_stack_occupancy #(
    .DEPTH(DEPTH)
  ) u_occ (
    .clk      (clk),
    .resetq   (resetq),
    .delta    (delta),
    .clear    (clear),
    .clr_flags(clr_flags),
    .level    (level),
    .overflow (overflow),
    .underflow(underflow),
    .fault    (fault)
  );

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

endmodule

// File: tb/tb_j1_stack_checked.sv
// Directed bench for j1_stack_checked (DEPTH=32, three taps).
// Each task drives one scenario and checks inline.
module tb_j1_stack_checked;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        we = 1'b0;
  logic [15:0] wd = '0;
  logic [1:0]  delta = 2'b00;
  logic        clear = 1'b0;
  logic        clr_flags = 1'b0;
  logic [15:0] rd1, rd2, rd3;
  logic [5:0]  level;
  logic        empty, full, overflow, underflow, fault;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP1 = 2'b11;
  localparam logic [1:0] POP2 = 2'b10;

  j1_stack_checked #(
    .WIDTH(16), .DEPTH(32), .RD_PORTS(3)
  ) dut (
    .clk(clk), .resetq(resetq), .we(we), .wd(wd),
    .delta(delta), .clear(clear), .clr_flags(clr_flags),
    .rd1(rd1), .rd2(rd2), .rd3(rd3), .level(level),
    .empty(empty), .full(full), .overflow(overflow),
    .underflow(underflow), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step(input logic w, input logic [15:0] d,
                      input logic [1:0] dl, input logic c,
                      input logic cf);
    we = w; wd = d; delta = dl; clear = c; clr_flags = cf;
    @(posedge clk);
    #1;
    we = 1'b0; delta = NONE; clear = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    resetq = 1'b0;
    #12;
    checks++; if (level !== 6'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b exp 10", empty, full); end
    checks++; if ({overflow, underflow, fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {overflow, underflow, fault}); end
    @(negedge clk);
    resetq = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_push3();
    step(1'b1, 16'h0011, PUSH, 1'b0, 1'b0);
    step(1'b1, 16'h0022, PUSH, 1'b0, 1'b0);
    step(1'b1, 16'h0033, PUSH, 1'b0, 1'b0);
    checks++; if (rd1 !== 16'h0033) begin errors++; $display("FAIL push3_rd1 got %h exp 0033", rd1); end
    checks++; if (rd2 !== 16'h0022) begin errors++; $display("FAIL push3_rd2 got %h exp 0022", rd2); end
    checks++; if (rd3 !== 16'h0011) begin errors++; $display("FAIL push3_rd3 got %h exp 0011", rd3); end
    checks++; if (level !== 6'd3) begin errors++; $display("FAIL push3_level got %0d exp 3", level); end
    checks++; if ({overflow, underflow, fault} !== 3'b000) begin errors++; $display("FAIL push3_flags got %b exp 000", {overflow, underflow, fault}); end
  endtask

  task automatic test_pop2();
    step(1'b0, 16'h0, POP2, 1'b0, 1'b0);
    checks++; if (rd1 !== 16'h0011) begin errors++; $display("FAIL pop2_rd1 got %h exp 0011", rd1); end
    checks++; if (level !== 6'd1) begin errors++; $display("FAIL pop2_level got %0d exp 1", level); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL pop2_nofault got %b exp 0", fault); end
    step(1'b0, 16'h0, POP2, 1'b0, 1'b0);
    checks++; if (level !== 6'd0) begin errors++; $display("FAIL pop2u_level got %0d exp 0", level); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL pop2u_underflow got %b exp 1", underflow); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL pop2u_fault got %b exp 1", fault); end
    // sp went 1 -> 31; two plain pushes bring it back to slot 1
    step(1'b0, 16'h0, PUSH, 1'b0, 1'b0);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL pop2u_fault_pulse got %b exp 0", fault); end
    step(1'b0, 16'h0, PUSH, 1'b0, 1'b0);
    checks++; if (rd1 !== 16'h0011) begin errors++; $display("FAIL pop2u_sp got %h exp 0011", rd1); end
    checks++; if (level !== 6'd2) begin errors++; $display("FAIL pop2u_relevel got %0d exp 2", level); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL pop2u_sticky got %b exp 1", underflow); end
  endtask

  task automatic test_overflow();
    step(1'b0, 16'h0, NONE, 1'b1, 1'b1);
    checks++; if ({level, overflow, underflow} !== 8'd0) begin errors++; $display("FAIL clear_all got %0d/%b%b exp 0/00", level, overflow, underflow); end
    for (int i = 0; i < 32; i++) step(1'b1, 16'h0100 + 16'(i), PUSH, 1'b0, 1'b0);
    checks++; if (level !== 6'd32 || full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf32 got lvl=%0d full=%b ovf=%b exp 32/1/0", level, full, overflow); end
    step(1'b1, 16'h0120, PUSH, 1'b0, 1'b0);
    checks++; if (level !== 6'd32) begin errors++; $display("FAIL ovf_level got %0d exp 32", level); end
    checks++; if (overflow !== 1'b1 || full !== 1'b1) begin errors++; $display("FAIL ovf_flags got ovf=%b full=%b exp 1/1", overflow, full); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ovf_fault got %b exp 1", fault); end
    checks++; if (rd1 !== 16'h0120 || rd2 !== 16'h011F) begin errors++; $display("FAIL ovf_rd got %h/%h exp 0120/011f", rd1, rd2); end
    step(1'b0, 16'h0, POP1, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL ovf_clr got ovf=%b fault=%b exp 0/0", overflow, fault); end
    for (int i = 0; i < 31; i++) step(1'b0, 16'h0, POP1, 1'b0, 1'b0);
    // the slot that held 0x0100 now holds the 33rd word
    checks++; if (rd1 !== 16'h0120 || level !== 6'd0) begin errors++; $display("FAIL ovf_wrap got %h/%0d exp 0120/0", rd1, level); end
    checks++; if (underflow !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL ovf_drain got unf=%b empty=%b exp 0/1", underflow, empty); end
  endtask

  task automatic test_overwrite();
    step(1'b0, 16'h0, NONE, 1'b1, 1'b1);
    step(1'b1, 16'h0AAA, PUSH, 1'b0, 1'b0);
    step(1'b1, 16'h0BBB, PUSH, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, NONE, 1'b0, 1'b0);
    checks++; if (rd1 !== 16'hBEEF || rd2 !== 16'h0AAA) begin errors++; $display("FAIL ovw_top got %h/%h exp beef/0aaa", rd1, rd2); end
    checks++; if (level !== 6'd2) begin errors++; $display("FAIL ovw_level got %0d exp 2", level); end
    step(1'b1, 16'h1234, POP1, 1'b0, 1'b0);
    checks++; if (rd1 !== 16'h1234 || level !== 6'd1) begin errors++; $display("FAIL ovw_under got %h/%0d exp 1234/1", rd1, level); end
  endtask

  task automatic test_same_cycle();
    step(1'b0, 16'h0, NONE, 1'b1, 1'b1);
    step(1'b0, 16'h0, POP1, 1'b0, 1'b1);
    checks++; if (underflow !== 1'b1 || fault !== 1'b1) begin errors++; $display("FAIL setwins got unf=%b fault=%b exp 1/1", underflow, fault); end
    step(1'b1, 16'h7777, PUSH, 1'b1, 1'b0);
    checks++; if (level !== 6'd0 || fault !== 1'b0) begin errors++; $display("FAIL clrpush got lvl=%0d fault=%b exp 0/0", level, fault); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL clrpush_keep got %b exp 1", underflow); end
    step(1'b0, 16'h0, PUSH, 1'b0, 1'b0);
    checks++; if (rd1 !== 16'h1234 || rd2 !== 16'h011F) begin errors++; $display("FAIL clrpush_sp got %h/%h exp 1234/011f", rd1, rd2); end
    checks++; if (level !== 6'd1) begin errors++; $display("FAIL clrpush_lvl got %0d exp 1", level); end
  endtask

  task automatic test_async_reset();
    step(1'b0, 16'h0, NONE, 1'b1, 1'b1);
    for (int i = 0; i < 33; i++) step(1'b0, 16'h0, PUSH, 1'b0, 1'b0);
    step(1'b0, 16'h0, NONE, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0200 + 16'(i), PUSH, 1'b0, 1'b0);
    checks++; if (level !== 6'd5 || overflow !== 1'b1) begin errors++; $display("FAIL pre_rst got %0d/%b exp 5/1", level, overflow); end
    #2;
    resetq = 1'b0;
    #1;
    checks++; if (level !== 6'd0) begin errors++; $display("FAIL arst_level got %0d exp 0", level); end
    checks++; if ({overflow, underflow, fault} !== 3'b000) begin errors++; $display("FAIL arst_flags got %b exp 000", {overflow, underflow, fault}); end
    @(negedge clk);
    resetq = 1'b1;
    step(1'b1, 16'h0ABC, PUSH, 1'b0, 1'b0);
    checks++; if (level !== 6'd1 || rd1 !== 16'h0ABC) begin errors++; $display("FAIL arst_push got %0d/%h exp 1/0abc", level, rd1); end
  endtask

  initial begin
    test_reset();
    test_push3();
    test_pop2();
    test_overflow();
    test_overwrite();
    test_same_cycle();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
